// File: rtl/chacha_poly_block_sequencer.sv
// Packs AAD and ciphertext byte streams into 16-byte Poly1305 blocks, zero-pads
// each segment and appends the {ct_len, aad_len} lengths block.
module chacha_poly_block_sequencer #(
  parameter int BEAT_BYTES = 16,  // 4, 8 or 16
  parameter int CNT_W      = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  input  logic [BEAT_BYTES-1:0]   in_keep,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    blk_valid,
  output logic [127:0]            blk_data,
  output logic                    blk_last,
  input  logic                    blk_ready,
  output logic                    aad_done,
  output logic                    pld_done,
  output logic                    lens_done,
  output logic                    busy,
  output logic                    err,
  output logic [CNT_W-1:0]        aad_len,
  output logic [CNT_W-1:0]        ct_len,
  output logic [2:0]              dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AAD  = 3'd1;
  localparam logic [2:0] S_PLD  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [127:0]     r_acc;
  logic [4:0]       r_fill;
  logic             r_flush;
  logic             r_blk_valid;
  logic [127:0]     r_blk_data;
  logic             r_blk_last;
  logic             r_aad_done, r_pld_done, r_lens_done, r_err;
  logic [CNT_W-1:0] r_aad_len, r_ct_len;

  logic             w_seg, w_out_free, w_accept, w_run, w_keep_bad, w_short, w_ovf;
  logic [4:0]       w_n, w_rem;
  logic [5:0]       w_total;
  logic [127:0]     w_beat, w_lens;
  logic [255:0]     w_cat;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;

  // Handshake: a beat moves when in_valid && in_ready; a block moves when
  // blk_valid && blk_ready. blk_data/blk_last hold while blk_valid && !blk_ready.
  assign w_seg      = (r_state == S_AAD) || (r_state == S_PLD);
  assign w_out_free = !r_blk_valid || blk_ready;
  assign in_ready   = w_seg && w_out_free && !r_flush && !start;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_n   = 5'd0;
    w_run = 1'b1;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (w_run && in_keep[i]) w_n = w_n + 5'd1;
      else w_run = 1'b0;
    end
  end

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (5'(i) < w_n) w_beat[8*i +: 8] = in_data[8*i +: 8];
    end
  end

  assign w_keep_bad = |(in_keep & (in_keep + 1'b1));
  assign w_short    = !in_last && (w_n < 5'(BEAT_BYTES));
  assign w_total    = {1'b0, r_fill} + {1'b0, w_n};
  assign w_rem      = 5'(w_total - 6'd16);
  // Bytes past 16 (only possible after a short non-last beat) spill into the next block.
  assign w_cat      = {128'd0, r_acc} | ({128'd0, w_beat} << {r_fill, 3'b000});

  assign w_cnt_sum  = {1'b0, (r_state == S_AAD) ? r_aad_len : r_ct_len} + (CNT_W+1)'(w_n);
  assign w_ovf      = w_cnt_sum[CNT_W];
  assign w_cnt_next = w_ovf ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
  assign w_lens     = {{(64-CNT_W){1'b0}}, r_ct_len, {(64-CNT_W){1'b0}}, r_aad_len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_fill      <= '0;
      r_flush     <= 1'b0;
      r_blk_valid <= 1'b0;
      r_blk_data  <= '0;
      r_blk_last  <= 1'b0;
      r_aad_done  <= 1'b0;
      r_pld_done  <= 1'b0;
      r_lens_done <= 1'b0;
      r_err       <= 1'b0;
      r_aad_len   <= '0;
      r_ct_len    <= '0;
    end else if (start) begin
      r_state     <= S_AAD;
      r_acc       <= '0;
      r_fill      <= '0;
      r_flush     <= 1'b0;
      r_blk_valid <= 1'b0;
      r_blk_data  <= '0;
      r_blk_last  <= 1'b0;
      r_aad_done  <= 1'b0;
      r_pld_done  <= 1'b0;
      r_lens_done <= 1'b0;
      r_err       <= 1'b0;
      r_aad_len   <= '0;
      r_ct_len    <= '0;
    end else begin
      if (r_blk_valid && blk_ready) r_blk_valid <= 1'b0;
      case (r_state)
        S_AAD, S_PLD: begin
          if (r_flush) begin
            if (w_out_free) begin
              r_blk_valid <= 1'b1;
              r_blk_data  <= r_acc;
              r_blk_last  <= 1'b0;
              r_acc       <= '0;
              r_fill      <= '0;
              r_flush     <= 1'b0;
              if (r_state == S_AAD) begin r_state <= S_PLD; r_aad_done <= 1'b1; end
              else                  begin r_state <= S_LEN; r_pld_done <= 1'b1; end
            end
          end else if (w_accept) begin
            if (w_keep_bad || w_short || w_ovf) r_err <= 1'b1;
            if (r_state == S_AAD) r_aad_len <= w_cnt_next;
            else                  r_ct_len  <= w_cnt_next;
            if (w_total >= 6'd16) begin
              r_blk_valid <= 1'b1;
              r_blk_data  <= w_cat[127:0];
              r_blk_last  <= 1'b0;
              r_acc       <= w_cat[255:128];
              r_fill      <= w_rem;
              if (in_last && (w_rem != 5'd0)) r_flush <= 1'b1;
              else if (in_last) begin
                if (r_state == S_AAD) begin r_state <= S_PLD; r_aad_done <= 1'b1; end
                else                  begin r_state <= S_LEN; r_pld_done <= 1'b1; end
              end
            end else if (in_last) begin
              if (w_total != 6'd0) begin
                r_blk_valid <= 1'b1;
                r_blk_data  <= w_cat[127:0];
                r_blk_last  <= 1'b0;
              end
              r_acc  <= '0;
              r_fill <= '0;
              if (r_state == S_AAD) begin r_state <= S_PLD; r_aad_done <= 1'b1; end
              else                  begin r_state <= S_LEN; r_pld_done <= 1'b1; end
            end else begin
              r_acc  <= w_cat[127:0];
              r_fill <= w_total[4:0];
            end
          end
        end
        S_LEN: begin
          // A valid block with blk_last set can only be the lengths block itself.
          if (r_blk_valid && r_blk_last) begin
            if (blk_ready) begin
              r_lens_done <= 1'b1;
              r_state     <= S_DONE;
            end
          end else if (w_out_free) begin
            r_blk_valid <= 1'b1;
            r_blk_data  <= w_lens;
            r_blk_last  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign blk_valid = r_blk_valid;
  assign blk_data  = r_blk_data;
  assign blk_last  = r_blk_last;
  assign aad_done  = r_aad_done;
  assign pld_done  = r_pld_done;
  assign lens_done = r_lens_done;
  assign busy      = w_seg || (r_state == S_LEN);
  assign err       = r_err;
  assign aad_len   = r_aad_len;
  assign ct_len    = r_ct_len;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_chacha_poly_block_sequencer.sv
// Directed bench: a 16-byte-beat instance runs most scenarios, a 4-byte-beat
// instance covers narrow beats; emitted blocks are scored against exp_q.
module tb_chacha_poly_block_sequencer;

  localparam int CNT_W = 40;

  logic clk, rst_n;

  logic             start, in_valid, in_last, in_ready, blk_valid, blk_last, blk_ready;
  logic [127:0]     in_data, blk_data;
  logic [15:0]      in_keep;
  logic             aad_done, pld_done, lens_done, busy, err;
  logic [CNT_W-1:0] aad_len, ct_len;
  logic [2:0]       dbg_state;

  logic             start4, in_valid4, in_last4, in_ready4, blk_valid4, blk_last4, blk_ready4;
  logic [31:0]      in_data4;
  logic [127:0]     blk_data4;
  logic [3:0]       in_keep4;
  logic             aad_done4, pld_done4, lens_done4, busy4, err4;
  logic [CNT_W-1:0] aad_len4, ct_len4;
  logic [2:0]       dbg_state4;

  logic [128:0] exp_q[$];
  logic [128:0] exp4_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  chacha_poly_block_sequencer #(.BEAT_BYTES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .in_ready(in_ready), .blk_valid(blk_valid),
    .blk_data(blk_data), .blk_last(blk_last), .blk_ready(blk_ready), .aad_done(aad_done),
    .pld_done(pld_done), .lens_done(lens_done), .busy(busy), .err(err),
    .aad_len(aad_len), .ct_len(ct_len), .dbg_state(dbg_state)
  );

  chacha_poly_block_sequencer #(.BEAT_BYTES(4), .CNT_W(CNT_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_data(in_data4),
    .in_keep(in_keep4), .in_last(in_last4), .in_ready(in_ready4), .blk_valid(blk_valid4),
    .blk_data(blk_data4), .blk_last(blk_last4), .blk_ready(blk_ready4), .aad_done(aad_done4),
    .pld_done(pld_done4), .lens_done(lens_done4), .busy(busy4), .err(err4),
    .aad_len(aad_len4), .ct_len(ct_len4), .dbg_state(dbg_state4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboards: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) check("blk16_unexpected", {1'b0, blk_last, blk_data}, '0);
      else check("blk16", {1'b0, blk_last, blk_data}, {1'b0, exp_q.pop_front()});
    end
    if (rst_n && blk_valid4 && blk_ready4) begin
      if (exp4_q.size() == 0) check("blk4_unexpected", {1'b0, blk_last4, blk_data4}, '0);
      else check("blk4", {1'b0, blk_last4, blk_data4}, {1'b0, exp4_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [127:0] seq(input logic [7:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b + 8'(i);
    return r;
  endfunction

  // Drivers: called just after a posedge; return just after the accepting posedge.
  task automatic send16(input logic [127:0] d, input logic [15:0] k, input logic l);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    check("beat16_timeout", {129'd0, in_ready}, 130'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l);
    in_valid4 = 1'b1; in_data4 = d; in_keep4 = k; in_last4 = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready4) begin
        step();
        in_valid4 = 1'b0; in_last4 = 1'b0;
        return;
      end
    end
    check("beat4_timeout", {129'd0, in_ready4}, 130'd1);
    in_valid4 = 1'b0; in_last4 = 1'b0;
  endtask

  task automatic wait_lens16();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lens_done) break;
    end
    check("lens_done", {129'd0, lens_done}, 130'd1);
  endtask

  task automatic wait_lens4();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lens_done4) break;
    end
    check("lens_done4", {129'd0, lens_done4}, 130'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    blk_ready = 1'b1;
    start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; in_keep4 = '0; in_last4 = 1'b0;
    blk_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_outputs", {blk_valid, blk_last, aad_done, pld_done, lens_done, busy, err, in_ready},
          '0);
    check("rst_blk_data", {2'b0, blk_data}, '0);
    check("rst_lens", {50'd0, aad_len, ct_len}, '0);
    check("rst_state", {127'd0, dbg_state}, '0);
    rst_n = 1'b1;
    step();

    // Scenario 1: 12-byte AAD, 20-byte ciphertext in beats of 16 and 4.
    pulse_start();
    exp_q.push_back({1'b0, 128'h00000000_0c0b0a09_08070605_04030201});
    exp_q.push_back({1'b0, 128'h1f1e1d1c_1b1a1918_17161514_13121110});
    exp_q.push_back({1'b0, 128'h00000000_00000000_00000000_23222120});
    exp_q.push_back({1'b1, 128'h00000000_00000014_00000000_0000000c});
    send16(seq(8'h01), 16'h0fff, 1'b1);
    send16(seq(8'h10), 16'hffff, 1'b0);
    send16(seq(8'h20), 16'h000f, 1'b1);
    wait_lens16();
    @(negedge clk);
    check("s1_lens", {50'd0, aad_len, ct_len}, {50'd0, 40'd12, 40'd20});
    check("s1_flags", {125'd0, aad_done, pld_done, lens_done, err, in_ready}, {125'd0, 5'b11100});
    check("s1_done_state", {126'd0, dbg_state, busy}, {126'd0, 3'd4, 1'b0});
    step();

    // Scenario 2: empty AAD, 32-byte ciphertext.
    pulse_start();
    exp_q.push_back({1'b0, 128'h1f1e1d1c_1b1a1918_17161514_13121110});
    exp_q.push_back({1'b0, 128'h2f2e2d2c_2b2a2928_27262524_23222120});
    exp_q.push_back({1'b1, 128'h00000000_00000020_00000000_00000000});
    send16(seq(8'h55), 16'h0000, 1'b1);
    @(negedge clk);
    check("s2_aad_done", {126'd0, aad_done, blk_valid, dbg_state[1:0]}, {126'd0, 4'b1010});
    step();
    send16(seq(8'h10), 16'hffff, 1'b0);
    send16(seq(8'h20), 16'hffff, 1'b1);
    wait_lens16();
    check("s2_lens", {50'd0, aad_len, ct_len}, {50'd0, 40'd0, 40'd32});
    step();

    // Scenario 3: downstream stalls for 5 cycles with a block pending.
    pulse_start();
    exp_q.push_back({1'b0, 128'h4f4e4d4c_4b4a4948_47464544_43424140});
    exp_q.push_back({1'b0, 128'h5f5e5d5c_5b5a5958_57565554_53525150});
    exp_q.push_back({1'b1, 128'h00000000_00000000_00000000_00000020});
    blk_ready = 1'b0;
    send16(seq(8'h40), 16'hffff, 1'b0);
    in_valid = 1'b1; in_data = seq(8'h50); in_keep = 16'hffff; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("s3_stall", {1'b0, in_ready, blk_valid, blk_data},
            {1'b0, 1'b0, 1'b1, 128'h4f4e4d4c_4b4a4948_47464544_43424140});
    end
    step();
    blk_ready = 1'b1;
    @(negedge clk);
    check("s3_resume_ready", {129'd0, in_ready}, 130'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    send16(seq(8'h00), 16'h0000, 1'b1);
    wait_lens16();
    check("s3_lens", {50'd0, aad_len, ct_len}, {50'd0, 40'd32, 40'd0});
    step();

    // Scenario 4: short non-last beat then non-contiguous keep on the last beat.
    pulse_start();
    exp_q.push_back({1'b0, 128'h00000000_00007170_67666564_63626160});
    exp_q.push_back({1'b1, 128'h00000000_00000000_00000000_0000000a});
    send16(seq(8'h60), 16'h00ff, 1'b0);
    @(negedge clk);
    check("s4_err_set", {129'd0, err}, 130'd1);
    step();
    send16(seq(8'h70), 16'h000b, 1'b1);
    send16(seq(8'h00), 16'h0000, 1'b1);
    wait_lens16();
    check("s4_result", {49'd0, err, aad_len, ct_len}, {49'd0, 1'b1, 40'd10, 40'd0});
    step();

    // Scenario 5: restart mid-ciphertext while a block is pending.
    pulse_start();
    send16(seq(8'h00), 16'h0000, 1'b1);
    blk_ready = 1'b0;
    send16(seq(8'h90), 16'hffff, 1'b0);
    @(negedge clk);
    check("s5_pending", {126'd0, blk_valid, dbg_state}, {126'd0, 1'b1, 3'd2});
    step();
    pulse_start();
    @(negedge clk);
    check("s5_cleared", {125'd0, blk_valid, aad_done, pld_done, lens_done, err}, '0);
    check("s5_counters", {50'd0, aad_len, ct_len}, '0);
    check("s5_state", {127'd0, dbg_state}, {127'd0, 3'd1});
    step();
    blk_ready = 1'b1;
    exp_q.push_back({1'b0, 128'h00000000_00000000_00000000_83828180});
    exp_q.push_back({1'b1, 128'h00000000_00000000_00000000_00000004});
    send16(seq(8'h80), 16'h000f, 1'b1);
    send16(seq(8'h00), 16'h0000, 1'b1);
    wait_lens16();
    check("s5_fresh", {49'd0, err, aad_len, ct_len}, {49'd0, 1'b0, 40'd4, 40'd0});
    step();

    // Scenario 6: 4-byte beats, 7-byte AAD, no ciphertext.
    pulse_start4_seq();
    exp4_q.push_back({1'b0, 128'h00000000_00000000_00070605_04030201});
    exp4_q.push_back({1'b1, 128'h00000000_00000000_00000000_00000007});
    send4(32'h04030201, 4'hf, 1'b0);
    send4(32'hff070605, 4'h7, 1'b1);
    send4(32'hdeadbeef, 4'h0, 1'b1);
    wait_lens4();
    check("s6_result", {49'd0, err4, aad_len4, ct_len4}, {49'd0, 1'b0, 40'd7, 40'd0});
    step();

    repeat (2) step();
    check("exp_q_drained", {98'd0, 32'(exp_q.size())}, '0);
    check("exp4_q_drained", {98'd0, 32'(exp4_q.size())}, '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic pulse_start4_seq();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
  endtask

endmodule
